// File: rtl/scratchpad_pkg.sv
// Shared types and helpers for the scratchpad TCM.
// Holds controller state encoding and lane-count derivation.
package scratchpad_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int byte_lanes(input int bits);
    return bits / 8;
  endfunction

endpackage

// File: rtl/scratchpad_bank.sv
// One byte lane of the scratchpad: simple dual-port RAM,
// synchronous read, read-old-data on same-address collision.
module scratchpad_bank #(
  parameter int ADDRESS_BITS = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDRESS_BITS-1:0] waddr,
  input  logic [7:0]              wdata,
  input  logic                    re,
  input  logic [ADDRESS_BITS-1:0] raddr,
  output logic [7:0]              rdata
);

  localparam int DEPTH = 1 << ADDRESS_BITS;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/scratchpad_tcm.sv
// Byte-lane scratchpad TCM with 1-cycle reads, optional
// write-to-read bypass and a zeroing clear engine.
module scratchpad_tcm
  import scratchpad_pkg::*;
#(
  parameter int BITS           = 32,
  parameter int ADDRESS_BITS   = 10,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    rd_req,
  input  logic [ADDRESS_BITS-1:0] rd_addr,
  output logic                    rd_valid,
  output logic [BITS-1:0]         rd_data,
  input  logic                    wr_req,
  input  logic [ADDRESS_BITS-1:0] wr_addr,
  input  logic [BITS-1:0]         wr_data,
  input  logic [BITS/8-1:0]       wr_be,
  input  logic                    clr_req,
  output logic                    ready,
  output logic                    busy
);

  localparam int LANES = byte_lanes(BITS);
  localparam logic [ADDRESS_BITS-1:0] LAST = '1;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [BITS-1:0]         last_q, last_d;
  logic                    byp_q, byp_d;
  logic [LANES-1:0]        be_q, be_d;
  logic [BITS-1:0]         wd_q, wd_d;

  logic            rd_acc;
  logic            wr_acc;
  logic            clearing;
  logic [BITS-1:0] merged;

  always_comb begin
    rd_acc   = rd_req && ready_q && RSTb;
    wr_acc   = wr_req && ready_q && RSTb;
    clearing = (state_q == ST_CLEAR) && RSTb;
    state_d  = state_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      state_q == ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_RUN;
      end
      state_q == ST_RUN: begin
        if (clr_req) state_d = ST_CLEAR;
      end
    endcase
    ready_d    = (state_d == ST_RUN);
    rd_valid_d = rd_acc;
    // Bypass only when both ports hit the same word this cycle.
    byp_d  = (RDW_MODE == RDW_NEW) && rd_acc && wr_acc
             && (rd_addr == wr_addr);
    be_d   = wr_be;
    wd_d   = wr_data;
    last_d = rd_valid_q ? merged : last_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q      <= '0;
      ready_q    <= (CLEAR_ON_RESET == 0);
      rd_valid_q <= 1'b0;
      last_q     <= '0;
      byp_q      <= 1'b0;
      be_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      last_q     <= last_d;
      byp_q      <= byp_d;
      be_q       <= be_d;
      wd_q       <= wd_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic                    we;
    logic [ADDRESS_BITS-1:0] wa;
    logic [7:0]              wd;
    logic [7:0]              rq;

    assign we = clearing || (wr_acc && wr_be[i]);
    assign wa = clearing ? cnt_q : wr_addr;
    assign wd = clearing ? 8'h00 : wr_data[8*i +: 8];

    scratchpad_bank #(
      .ADDRESS_BITS(ADDRESS_BITS)
    ) u_bank (
      .clk  (CLK),
      .we   (we),
      .waddr(wa),
      .wdata(wd),
      .re   (rd_acc),
      .raddr(rd_addr),
      .rdata(rq)
    );

    assign merged[8*i +: 8] =
      (byp_q && be_q[i]) ? wd_q[8*i +: 8] : rq;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? merged : last_q;
  assign ready    = ready_q;
  assign busy     = !ready_q;

endmodule

// File: tb/tb_scratchpad_tcm.sv
// Bench for scratchpad_tcm: old-data and new-data instances
// share stimulus and are checked against a word-level model.
module tb_scratchpad_tcm;

  localparam int BITS  = 32;
  localparam int AB    = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RSTb;
  logic          rd_req;
  logic [AB-1:0] rd_addr;
  logic          wr_req;
  logic [AB-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          clr_req;

  logic        v0, v1, rdy0, rdy1, bsy0, bsy1;
  logic [31:0] d0, d1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  scratchpad_tcm #(
    .BITS(BITS), .ADDRESS_BITS(AB),
    .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_old (
    .CLK(CLK), .RSTb(RSTb),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(v0), .rd_data(d0),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .ready(rdy0), .busy(bsy0)
  );

  scratchpad_tcm #(
    .BITS(BITS), .ADDRESS_BITS(AB),
    .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_new (
    .CLK(CLK), .RSTb(RSTb),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(v1), .rd_data(d1),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .ready(rdy1), .busy(bsy1)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Word-level reference: memory array, clear countdown, read result.
  logic [31:0] m [DEPTH];
  int          left = 0;
  bit          live = 0;
  bit          ev = 0;
  logic [31:0] ed0 = '0;
  logic [31:0] ed1 = '0;

  always @(posedge CLK) begin
    logic [31:0] old;
    if (!RSTb) begin
      live = 1;
      left = DEPTH;
      ev   = 0;
      ed0  = '0;
      ed1  = '0;
      for (int a = 0; a < DEPTH; a++) m[a] = '0;
    end else if (left > 0) begin
      left--;
      ev = 0;
    end else begin
      ev = 0;
      if (rd_req) begin
        old = m[rd_addr];
        ed0 = old;
        ed1 = (wr_req && wr_addr == rd_addr)
              ? merge(old, wr_data, wr_be) : old;
        ev  = 1;
      end
      if (wr_req) m[wr_addr] = merge(m[wr_addr], wr_data, wr_be);
      if (clr_req) begin
        for (int a = 0; a < DEPTH; a++) m[a] = '0;
        left = DEPTH;
      end
    end
  end

  always @(negedge CLK) begin
    if (live) begin
      chk("ready_old", {31'b0, rdy0}, {31'b0, left == 0});
      chk("ready_new", {31'b0, rdy1}, {31'b0, left == 0});
      chk("busy_old", {31'b0, bsy0}, {31'b0, left != 0});
      chk("busy_new", {31'b0, bsy1}, {31'b0, left != 0});
      chk("valid_old", {31'b0, v0}, {31'b0, ev});
      chk("valid_new", {31'b0, v1}, {31'b0, ev});
      chk("data_old", d0, ed0);
      chk("data_new", d1, ed1);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    rd_req  = 0;
    wr_req  = 0;
    clr_req = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d,
                    input logic [3:0] be);
    idle();
    wr_req  = 1;
    wr_addr = AB'(a);
    wr_data = d;
    wr_be   = be;
    cyc();
    idle();
  endtask

  task automatic rd(input int a);
    idle();
    rd_req  = 1;
    rd_addr = AB'(a);
    cyc();
    idle();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!rdy0 && n < 64);
    chk(name, 32'(n), 32'd16);
  endtask

  initial begin
    RSTb = 0;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    cyc();
    cyc();
    chk("rst_ready", {31'b0, rdy0}, 32'd0);
    chk("rst_busy", {31'b0, bsy1}, 32'd1);
    chk("rst_valid", {31'b0, v0}, 32'd0);
    chk("rst_data", d1, 32'd0);

    RSTb = 1;
    wait_ready("clr_len_reset");
    for (int a = 0; a < DEPTH; a++) begin
      rd(a);
      chk("zero_valid", {31'b0, v0}, 32'd1);
      chk("zero_data", d0, 32'h0);
    end

    wr(3, 32'hDEADBEEF, 4'b1111);
    wr(3, 32'h11223344, 4'b0101);
    rd(3);
    chk("be_merge_old", d0, 32'hDE22BE44);
    chk("be_merge_new", d1, 32'hDE22BE44);

    wr(5, 32'hAAAAAAAA, 4'b1111);
    rd_req  = 1;
    rd_addr = 5;
    wr_req  = 1;
    wr_addr = 5;
    wr_data = 32'h55555555;
    wr_be   = 4'b0011;
    cyc();
    idle();
    chk("rdw_old", d0, 32'hAAAAAAAA);
    chk("rdw_new", d1, 32'hAAAA5555);
    rd(5);
    chk("rdw_after_old", d0, 32'hAAAA5555);
    chk("rdw_after_new", d1, 32'hAAAA5555);

    clr_req = 1;
    cyc();
    clr_req = 0;
    for (int i = 0; i < 16; i++) begin
      rd_req  = 1;
      rd_addr = 3;
      wr_req  = 1;
      wr_addr = 3;
      wr_data = 32'hFFFFFFFF;
      wr_be   = 4'hF;
      cyc();
      chk("clr_drop_valid", {31'b0, v0}, 32'd0);
    end
    idle();
    chk("clr_ready_back", {31'b0, rdy0}, 32'd1);
    rd(3);
    chk("clr_zero_a3", d0, 32'h0);

    clr_req = 1;
    cyc();
    clr_req = 0;
    repeat (7) cyc();
    RSTb = 0;
    cyc();
    RSTb = 1;
    wait_ready("clr_len_restart");

    wr(0, 32'd1, 4'hF);
    wr(1, 32'd2, 4'hF);
    wr(2, 32'd3, 4'hF);
    for (int i = 0; i < 3; i++) begin
      rd_req  = 1;
      rd_addr = AB'(i);
      cyc();
      chk("b2b_valid", {31'b0, v1}, 32'd1);
      chk("b2b_data", d1, 32'(i + 1));
    end
    idle();
    cyc();
    chk("b2b_end", {31'b0, v0}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      rd_req  = 1'($urandom_range(0, 1));
      wr_req  = 1'($urandom_range(0, 1));
      rd_addr = AB'($urandom_range(0, 15));
      wr_addr = ($urandom_range(0, 2) == 0)
                ? rd_addr : AB'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 149) == 0);
      cyc();
    end
    idle();
    repeat (20) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
